// File: rtl/boundary_monitor.sv
// Registered region-boundary monitor: classifies each valid address into one of
// 2**R_LOG2 equal regions, flags boundary hits and tracks region changes.
module boundary_monitor #(
  parameter int unsigned N      = 16,
  parameter int unsigned R_LOG2 = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   addr_valid,
  input  logic [N-1:0]           address,
  input  logic                   clear,
  output logic                   out_valid,
  output logic                   boundary_flag,
  output logic [R_LOG2-1:0]      region,
  output logic                   region_change,
  output logic                   first,
  output logic [CNT_W-1:0]       boundary_count,
  output logic [(2**R_LOG2)-1:0] hit_mask
);

  localparam int unsigned OFF_W   = N - R_LOG2;
  localparam int unsigned REGIONS = 2 ** R_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t              state;
  logic [R_LOG2-1:0]   last_region;

  logic [R_LOG2-1:0]   region_c;
  logic                on_boundary_c;
  logic                hit_c;

  // Region is the top slice; a boundary has an all-zero offset within its region.
  assign region_c      = address[N-1 -: R_LOG2];
  assign on_boundary_c = (address[OFF_W-1:0] == OFF_W'(0));
  assign hit_c         = addr_valid && on_boundary_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_region    <= '0;
      out_valid      <= 1'b0;
      boundary_flag  <= 1'b0;
      region         <= '0;
      region_change  <= 1'b0;
      first          <= 1'b0;
      boundary_count <= '0;
      hit_mask       <= '0;
    end else begin
      out_valid     <= addr_valid;
      boundary_flag <= hit_c;
      region_change <= 1'b0;
      first         <= 1'b0;

      // Tracking FSM; region and last_region hold across gaps.
      if (addr_valid) begin
        region      <= region_c;
        last_region <= region_c;
        case (state)
          IDLE: begin
            state <= TRACK;
            first <= 1'b1;
          end
          TRACK: begin
            region_change <= (region_c != last_region);
          end
          default: state <= IDLE;
        endcase
      end

      // Statistics; clear takes priority over a same-cycle hit.
      if (clear) begin
        boundary_count <= '0;
        hit_mask       <= '0;
      end else if (hit_c) begin
        if (boundary_count != CNT_MAX) begin
          boundary_count <= boundary_count + CNT_W'(1);
        end
        hit_mask[region_c] <= 1'b1;
      end
    end
  end

  // REGIONS must match the hit_mask width.
  if (REGIONS != $bits(hit_mask)) begin : g_width_guard
    $error("hit_mask width mismatch");
  end

endmodule

// File: doc/boundary_monitor.md
# boundary_monitor

Parametrised, registered region-boundary monitor for an address bus. The address range is split into 2**R_LOG2 equal regions. For each valid address the block flags region-boundary hits, reports the region index and detects region changes between consecutive valid addresses. It also keeps a saturating boundary-hit counter and sticky per-region hit bits. It sits beside address decoders and bus monitors as the clocked, generalised replacement for a combinational quadrant-boundary flag.

## Interface
Parameters:
- N, 16, address width in bits.
- R_LOG2, 2, log2 of the region count. Legal range is 1..N-1. The default gives 4 quadrants.
- CNT_W, 8, width of the boundary-hit counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr_valid  input  1  qualifies address for this cycle.
- address  input  N  address to classify.
- clear  input  1  synchronous clear of boundary_count and hit_mask only.
- out_valid  output  1  registered copy of addr_valid; qualifies boundary_flag, region, region_change and first.
- boundary_flag  output  1  sampled address was on a region boundary.
- region  output  R_LOG2  region index of the sampled address.
- region_change  output  1  sampled region differs from the region of the previous valid address.
- first  output  1  sampled address was the first valid address since reset.
- boundary_count  output  CNT_W  saturating count of boundary hits.
- hit_mask  output  2**R_LOG2  sticky bit per region; bit k set once region k's boundary has been hit.

Reset is synchronous and active-high on rst. All outputs are 0 after reset.

## Operation
- Region index is address[N-1 -: R_LOG2].
- An address is a boundary when address[N-R_LOG2-1:0] == 0. With N=16 and R_LOG2=2 the boundaries are 0x0000, 0x4000, 0x8000 and 0xC000.
- Tracking FSM, two states:
  - IDLE is the reset state, with no previous address.
  - TRACK holds the region of the last valid address in last_region.
  - IDLE on addr_valid: go to TRACK, load last_region, first=1, region_change=0.
  - TRACK on addr_valid: region_change = (region != last_region), then update last_region.
  - Without addr_valid the state and last_region hold.
- When addr_valid=0, out_valid=0 and boundary_flag, region_change and first are 0. region holds its last value.
- boundary_count:
  - Increments by 1 on each valid boundary address.
  - Saturates at 2**CNT_W-1 and never wraps.
  - clear forces it to 0. When clear and a hit occur in the same cycle, clear wins and the result is 0.
- hit_mask:
  - A valid boundary address in region k sets bit k.
  - Bits are only cleared by rst or clear. Clear wins over a same-cycle set.
- clear does not affect the FSM, last_region or the per-sample outputs.
- rst asserted mid-stream:
  - On the next edge all outputs become 0 and the FSM returns to IDLE.
  - Any addr_valid in that cycle is discarded.
  - The next valid address after rst is reported with first=1.
- All arithmetic is unsigned. The boundary test uses a bit-slice compare, not division, so it is legal for any N and R_LOG2.

## Timing
- Latency is 1 cycle. A sample presented on edge t is reported on out_valid and its companion outputs after edge t, during cycle t+1.
- boundary_count and hit_mask include the sample from edge t after that same edge, so they are aligned with out_valid.
- There is no backpressure. A new sample is accepted every cycle.
- No combinational path exists from inputs to outputs.

## Test plan
- Reset: hold rst for 2 cycles with addr_valid=1 and address=0x4000 → every output is 0 and the FSM is in IDLE. The first valid address after rst deasserts reports first=1.
- Boundary sweep (N=16, R_LOG2=2): drive 0x0000, 0x4000, 0x8000, 0xC000 on consecutive cycles, then 0x0001 → boundary_flag is 1,1,1,1,0 and region is 0,1,2,3,0. region_change is 0,1,1,1,1, with first=1 on the first sample only. The sweep ends with boundary_count=4 and hit_mask=4'b1111.
- Gaps: drive 0x4001, then 3 cycles of addr_valid=0, then 0x7FFF → region_change=0 on the second sample (same region 1), and out_valid=0 during the gap.
- Saturation (CNT_W=3): drive 10 valid boundary hits → boundary_count reads 1..7 and then holds at 7.
- Clear collision: with boundary_count=5 and hit_mask=4'b0011, assert clear while driving 0x8000 → boundary_count=0 and hit_mask=0. That sample still reports boundary_flag=1 and region=2, and the FSM is unaffected.
- Generalisation (N=8, R_LOG2=3): drive 0x20 then 0x21 → boundary_flag is 1 then 0, and region is 1 both times with region_change=0. hit_mask=8'b0000_0010.
